ddr_ail_ctrl: RTL and testbench



---
 rtl/ddr_ail_pkg.sv | 48 ++++
 rtl/ail_sync2.sv | 33 +++
 rtl/ddr_ail_ctrl.sv | 167 ++++++++++++++++
 tb/tb_ddr_ail_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_ail_pkg.sv
// -----------------------------------------------------------------------------
// ddr_ail_pkg
// Shared types and constants for the DDR input-register alignment (AIL)
// sequencing controller.
//   - ail_state_t   : FSM state encoding. It is visible on the STATE debug port,
//                     so the numeric values are fixed.
//   - ail_out_t     : the per-state pin bundle driven toward the IDDR and the
//                     link bring-up logic.
//   - state_outputs : maps a state to its output bundle. The FSM loads the
//                     output register with this value on the same edge that it
//                     loads the state register.
// -----------------------------------------------------------------------------
package ddr_ail_pkg;

  localparam int CNT_W   = 16;  // ARST / WAITL cycle counter
  localparam int RETRY_W = 4;   // timeouts in the current bring-up
  localparam int LOSS_W  = 4;   // consecutive low synchronized-lock cycles

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARST   = 3'd1,
    ST_WAITL  = 3'd2,
    ST_LOCKED = 3'd3,
    ST_FAIL   = 3'd4
  } ail_state_t;

  typedef struct packed {
    logic rstail;
    logic runail;
    logic iddr_rst;
    logic ready;
    logic fail;
  } ail_out_t;

  function automatic ail_out_t state_outputs(input ail_state_t s);
    ail_out_t o;
    case (s)
      ST_IDLE:   o = '{rstail: 1'b1, runail: 1'b0, iddr_rst: 1'b1, ready: 1'b0, fail: 1'b0};
      ST_ARST:   o = '{rstail: 1'b1, runail: 1'b0, iddr_rst: 1'b1, ready: 1'b0, fail: 1'b0};
      ST_WAITL:  o = '{rstail: 1'b0, runail: 1'b1, iddr_rst: 1'b1, ready: 1'b0, fail: 1'b0};
      ST_LOCKED: o = '{rstail: 1'b0, runail: 1'b0, iddr_rst: 1'b0, ready: 1'b1, fail: 1'b0};
      ST_FAIL:   o = '{rstail: 1'b1, runail: 1'b0, iddr_rst: 1'b1, ready: 1'b0, fail: 1'b1};
      default:   o = '{rstail: 1'b1, runail: 1'b0, iddr_rst: 1'b1, ready: 1'b0, fail: 1'b0};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/ail_sync2.sv
// -----------------------------------------------------------------------------
// ail_sync2
// Two-flop synchronizer that brings the IDDR LOCK flag into the SCLK domain.
// Reset is synchronous and clears both flops.
// Ports:
//   i_clk  : destination clock
//   i_srst : synchronous active-high reset
//   i_d    : asynchronous input
//   o_q    : synchronized output (second flop)
// -----------------------------------------------------------------------------
module ail_sync2 (
  input  logic i_clk,
  input  logic i_srst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/ddr_ail_ctrl.sv
// -----------------------------------------------------------------------------
// ddr_ail_ctrl
// Sequences the IDDR alignment logic through reset -> train -> lock. A training
// attempt that times out is retried a bounded number of times. The datapath is
// held in reset until lock is reached, and a filtered loss of lock starts a new
// training round automatically.
// Ports:
//   SCLK      : system clock; all state changes on the rising edge
//   RST       : synchronous active-high reset
//   START     : level request (1 = bring up / keep the link, 0 = abort to IDLE)
//   LOCK_IN   : IDDR LOCK, asynchronous to SCLK
//   RSTAIL_O  : to IDDR RSTAIL
//   RUNAIL_O  : to IDDR RUNAIL
//   IDDR_RST  : to IDDR RST (datapath reset)
//   READY     : link locked, data valid
//   FAIL      : retries exhausted; stays set until START is dropped
//   LOSS      : one-cycle pulse when a lock loss is detected
//   RETRY_CNT : timeouts seen in the current bring-up
//   STATE     : current state encoding (debug)
// Every output is a register, so there is no combinational path from any
// input to any output.
// -----------------------------------------------------------------------------
module ddr_ail_ctrl
  import ddr_ail_pkg::*;
#(
  parameter int unsigned RST_CYCLES   = 4,
  parameter int unsigned LOCK_TIMEOUT = 255,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned LOSS_FILTER  = 2
) (
  input  logic               SCLK,
  input  logic               RST,
  input  logic               START,
  input  logic               LOCK_IN,
  output logic               RSTAIL_O,
  output logic               RUNAIL_O,
  output logic               IDDR_RST,
  output logic               READY,
  output logic               FAIL,
  output logic               LOSS,
  output logic [RETRY_W-1:0] RETRY_CNT,
  output logic [2:0]         STATE
);

  // Terminal counts. Each comparison happens on the last cycle of a phase, so
  // it is made against N-1.
  localparam logic [CNT_W-1:0]   RST_LAST   = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);
  localparam logic [LOSS_W-1:0]  LOSS_LAST  = LOSS_W'(LOSS_FILTER - 1);

  logic w_lock_s;

  ail_state_t         r_state;
  ail_out_t           r_out;
  logic [CNT_W-1:0]   r_cnt;
  logic [RETRY_W-1:0] r_retry;
  logic [LOSS_W-1:0]  r_loss_cnt;
  logic               r_loss;

  ail_sync2 u_lock_sync (
    .i_clk  (SCLK),
    .i_srst (RST),
    .i_d    (LOCK_IN),
    .o_q    (w_lock_s)
  );

  always_ff @(posedge SCLK) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      r_out      <= state_outputs(ST_IDLE);
      r_cnt      <= '0;
      r_retry    <= '0;
      r_loss_cnt <= '0;
      r_loss     <= 1'b0;
    end else begin
      r_loss <= 1'b0;
      if (!START) begin
        // An abort overrides every other transition. The retry count is
        // cleared so that a new bring-up starts from a clean slate.
        r_state    <= ST_IDLE;
        r_out      <= state_outputs(ST_IDLE);
        r_cnt      <= '0;
        r_retry    <= '0;
        r_loss_cnt <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_ARST;
            r_out   <= state_outputs(ST_ARST);
            r_retry <= '0;
            r_cnt   <= '0;
          end

          ST_ARST: begin
            if (r_cnt == RST_LAST) begin
              r_state <= ST_WAITL;
              r_out   <= state_outputs(ST_WAITL);
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end

          ST_WAITL: begin
            // If lock arrives on the timeout cycle, lock takes priority.
            if (w_lock_s) begin
              r_state    <= ST_LOCKED;
              r_out      <= state_outputs(ST_LOCKED);
              r_cnt      <= '0;
              r_loss_cnt <= '0;
            end else if (r_cnt == TO_LAST) begin
              r_cnt <= '0;
              if (r_retry < RETRY_MAX) begin
                r_retry <= r_retry + RETRY_W'(1);
                r_state <= ST_ARST;
                r_out   <= state_outputs(ST_ARST);
              end else begin
                r_state <= ST_FAIL;
                r_out   <= state_outputs(ST_FAIL);
              end
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end

          ST_LOCKED: begin
            // Only an uninterrupted run of LOSS_FILTER low samples counts as
            // a loss. A single high sample restarts the run.
            if (w_lock_s) begin
              r_loss_cnt <= '0;
            end else if (r_loss_cnt == LOSS_LAST) begin
              r_state    <= ST_ARST;
              r_out      <= state_outputs(ST_ARST);
              r_loss     <= 1'b1;
              r_retry    <= '0;
              r_cnt      <= '0;
              r_loss_cnt <= '0;
            end else begin
              r_loss_cnt <= r_loss_cnt + LOSS_W'(1);
            end
          end

          ST_FAIL: begin
            // Held here until START drops.
          end

          default: begin
            r_state <= ST_IDLE;
            r_out   <= state_outputs(ST_IDLE);
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign RSTAIL_O  = r_out.rstail;
  assign RUNAIL_O  = r_out.runail;
  assign IDDR_RST  = r_out.iddr_rst;
  assign READY     = r_out.ready;
  assign FAIL      = r_out.fail;
  assign LOSS      = r_loss;
  assign RETRY_CNT = r_retry;
  assign STATE     = r_state;

endmodule

// File: tb/tb_ddr_ail_ctrl.sv
module tb_ddr_ail_ctrl;

  localparam int RC = 4;
  localparam int LT = 40;
  localparam int MR = 2;
  localparam int LF = 3;

  logic       SCLK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic       LOCK_IN = 1'b0;
  logic       RSTAIL_O, RUNAIL_O, IDDR_RST, READY, FAIL, LOSS;
  logic [3:0] RETRY_CNT;
  logic [2:0] STATE;

  ddr_ail_ctrl #(
    .RST_CYCLES   (RC),
    .LOCK_TIMEOUT (LT),
    .MAX_RETRY    (MR),
    .LOSS_FILTER  (LF)
  ) dut (
    .SCLK      (SCLK),
    .RST       (RST),
    .START     (START),
    .LOCK_IN   (LOCK_IN),
    .RSTAIL_O  (RSTAIL_O),
    .RUNAIL_O  (RUNAIL_O),
    .IDDR_RST  (IDDR_RST),
    .READY     (READY),
    .FAIL      (FAIL),
    .LOSS      (LOSS),
    .RETRY_CNT (RETRY_CNT),
    .STATE     (STATE)
  );

  always #5 SCLK = ~SCLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit cmp_en = 0;

  // Behavioural reference: state id, edge of entry, retries, run of low lock.
  int m_edge = 0;
  int m_state = 0;
  int m_enter = 0;
  int m_retry = 0;
  int m_lowrun = 0;
  bit m_loss = 0;
  bit m_dly[2] = '{1'b0, 1'b0};  // LOCK_IN as seen 1 and 2 edges ago

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [4:0] exp_outs(input int s);
    // {RSTAIL_O, RUNAIL_O, IDDR_RST, READY, FAIL}
    case (s)
      2:       return 5'b01100;
      3:       return 5'b00010;
      4:       return 5'b10101;
      default: return 5'b10100;
    endcase
  endfunction

  task automatic m_go(input int s);
    m_state  = s;
    m_enter  = m_edge;
    m_lowrun = 0;
  endtask

  // One rising edge of the reference, using the inputs the DUT samples.
  task automatic model_step();
    bit ls;
    ls = m_dly[1];
    m_edge++;
    m_loss = 0;
    if (RST) begin
      m_dly = '{1'b0, 1'b0};
      m_retry = 0;
      m_go(0);
    end else begin
      m_dly[1] = m_dly[0];
      m_dly[0] = LOCK_IN;
      if (!START) begin
        m_retry = 0;
        m_go(0);
      end else begin
        case (m_state)
          0: begin m_retry = 0; m_go(1); end
          1: if (m_edge - m_enter == RC) m_go(2);
          2: begin
            if (ls) m_go(3);
            else if (m_edge - m_enter == LT) begin
              if (m_retry < MR) begin m_retry++; m_go(1); end
              else m_go(4);
            end
          end
          3: begin
            if (ls) m_lowrun = 0;
            else begin
              m_lowrun++;
              if (m_lowrun == LF) begin
                m_go(1);
                m_loss = 1;
                m_retry = 0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  endtask

  task automatic tick();
    @(posedge SCLK);
    model_step();
    @(negedge SCLK);
    cyc++;
  endtask

  // Per-cycle comparison against the reference.
  always @(negedge SCLK) begin
    if (cmp_en) begin
      chk("model_state", {13'd0, STATE}, m_state[15:0]);
      chk("model_retry", {12'd0, RETRY_CNT}, m_retry[15:0]);
      chk("model_loss", {15'd0, LOSS}, {15'd0, m_loss});
      chk("model_outs", {11'd0, RSTAIL_O, RUNAIL_O, IDDR_RST, READY, FAIL},
          {11'd0, exp_outs(m_state)});
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rstail"}, {15'd0, RSTAIL_O}, 16'd1);
    chk({tag, "_runail"}, {15'd0, RUNAIL_O}, 16'd0);
    chk({tag, "_iddr_rst"}, {15'd0, IDDR_RST}, 16'd1);
    chk({tag, "_ready"}, {15'd0, READY}, 16'd0);
    chk({tag, "_fail"}, {15'd0, FAIL}, 16'd0);
    chk({tag, "_loss"}, {15'd0, LOSS}, 16'd0);
    chk({tag, "_retry"}, {12'd0, RETRY_CNT}, 16'd0);
    chk({tag, "_state"}, {13'd0, STATE}, 16'd0);
  endtask

  bit lock_lvl;
  int lock_run;
  int start_off;

  initial begin
    RST = 1'b1; START = 1'b0; LOCK_IN = 1'b0;
    tick();
    cmp_en = 1;
    tick();
    RST = 1'b0;
    chk_reset_vals("reset");
    $display("reset: outputs checked at cycle %0d", cyc);

    // Nominal bring-up: START in cycle 0, LOCK_IN high from cycle 10.
    cyc = 0;
    START = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("nom_runail", {15'd0, RUNAIL_O}, {15'd0, (k >= 5 && k <= 12)});
      chk("nom_ready", {15'd0, READY}, {15'd0, (k >= 13)});
      chk("nom_iddr_rst", {15'd0, IDDR_RST}, {15'd0, (k < 13)});
      if (k == 10) LOCK_IN = 1'b1;
    end
    chk("nom_retry", {12'd0, RETRY_CNT}, 16'd0);
    $display("nominal: READY=%0b STATE=%0d", READY, STATE);

    // Glitch shorter than the filter: READY must hold.
    LOCK_IN = 1'b0;
    tick(); tick();
    LOCK_IN = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("glitch_ready_hold", {15'd0, READY}, 16'd1);
    end
    // Sustained loss: ARST with LOSS pulse after 2+LF edges.
    LOCK_IN = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 4) chk("loss_ready_k4", {15'd0, READY}, 16'd1);
      if (k == 5) begin
        chk("loss_pulse", {15'd0, LOSS}, 16'd1);
        chk("loss_state", {13'd0, STATE}, 16'd1);
        chk("loss_ready", {15'd0, READY}, 16'd0);
        chk("loss_retry", {12'd0, RETRY_CNT}, 16'd0);
      end
      if (k == 6) chk("loss_pulse_end", {15'd0, LOSS}, 16'd0);
    end
    $display("glitch/loss: STATE=%0d", STATE);

    // Timeout rounds then FAIL, then abort.
    START = 1'b0;
    tick();
    chk("abort_idle", {13'd0, STATE}, 16'd0);
    cyc = 0;
    START = 1'b1;
    for (int k = 1; k <= 140; k++) begin
      tick();
      if (k == 44)  chk("to_r0_state", {13'd0, STATE}, 16'd2);
      if (k == 45)  chk("to_r1_retry", {12'd0, RETRY_CNT}, 16'd1);
      if (k == 45)  chk("to_r1_state", {13'd0, STATE}, 16'd1);
      if (k == 89)  chk("to_r2_retry", {12'd0, RETRY_CNT}, 16'd2);
      if (k == 132) chk("to_fail_pre", {15'd0, FAIL}, 16'd0);
      if (k == 133) chk("to_fail", {15'd0, FAIL}, 16'd1);
      if (k == 133) chk("to_fail_state", {13'd0, STATE}, 16'd4);
      if (k == 140) chk("to_fail_hold", {15'd0, FAIL}, 16'd1);
    end
    START = 1'b0;
    tick();
    chk("fail_clear", {15'd0, FAIL}, 16'd0);
    chk("fail_clear_state", {13'd0, STATE}, 16'd0);
    $display("timeout/fail: FAIL=%0b STATE=%0d", FAIL, STATE);

    // Lock arriving on the last WAITL cycle of the second round.
    cyc = 0;
    START = 1'b1;
    for (int k = 1; k <= 92; k++) begin
      tick();
      if (k == 45) chk("bnd_retry1", {12'd0, RETRY_CNT}, 16'd1);
      if (k == 86) LOCK_IN = 1'b1;
      if (k == 88) chk("bnd_waitl", {13'd0, STATE}, 16'd2);
      if (k == 89) begin
        chk("bnd_locked", {13'd0, STATE}, 16'd3);
        chk("bnd_retry_kept", {12'd0, RETRY_CNT}, 16'd1);
        chk("bnd_ready", {15'd0, READY}, 16'd1);
      end
    end
    $display("boundary: STATE=%0d RETRY_CNT=%0d", STATE, RETRY_CNT);

    // Reset while LOCKED.
    RST = 1'b1;
    tick();
    chk_reset_vals("mid_reset");
    RST = 1'b0;
    LOCK_IN = 1'b0;
    // START still high: bring-up restarts; abort during WAITL.
    for (int k = 1; k <= 7; k++) tick();
    chk("abort_in_waitl", {13'd0, STATE}, 16'd2);
    START = 1'b0;
    tick();
    chk("abort_state", {13'd0, STATE}, 16'd0);
    chk("abort_rstail", {15'd0, RSTAIL_O}, 16'd1);
    chk("abort_runail", {15'd0, RUNAIL_O}, 16'd0);
    $display("abort/reset: STATE=%0d", STATE);

    // Randomized traffic against the reference model.
    lock_lvl = 1'b0;
    lock_run = 0;
    start_off = 0;
    for (int n = 0; n < 5000; n++) begin
      if (lock_run == 0) begin
        lock_lvl = ~lock_lvl;
        if (lock_lvl) lock_run = $urandom_range(80, 1);
        else if ($urandom_range(1, 0) == 0) lock_run = $urandom_range(4, 1);
        else lock_run = $urandom_range(200, 20);
      end
      LOCK_IN = lock_lvl;
      lock_run--;
      if (start_off > 0) begin
        START = 1'b0;
        start_off--;
      end else if ($urandom_range(299, 0) == 0) begin
        START = 1'b0;
        start_off = $urandom_range(5, 1);
      end else begin
        START = 1'b1;
      end
      RST = ($urandom_range(799, 0) == 0);
      tick();
    end
    RST = 1'b0;
    $display("random: %0d cycles done", 5000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
